// File: rtl/fp_mul_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_rr_sched
// Purpose  : Round-robin share of one external combinational FP multiplier
//            between NREQ requesters, two-stage registered pipeline.
// Revision : 1.0
// ============================================================================
module fp_mul_rr_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic [31:0]          mul_p,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_data,
  output logic                 busy,
  output logic [CNTW-1:0]      op_count
);

  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);
  localparam logic [IDW:0]   NREQ_W  = (IDW + 1)'(NREQ);

  logic              s1_valid_q, s1_valid_d;
  logic [IDW-1:0]    s1_id_q, s1_id_d;
  logic [31:0]       mul_a_q, mul_a_d;
  logic [31:0]       mul_b_q, mul_b_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [CNTW-1:0]   op_count_q, op_count_d;

  logic              s2_load;
  logic              s1_load;
  logic              grant_en;
  logic              found;
  logic [IDW:0]      cand;
  logic [IDW-1:0]    cand_id;
  logic [IDW-1:0]    win_id;
  logic [31:0]       sel_a;
  logic [31:0]       sel_b;

  assign s2_load  = !rsp_valid_q | rsp_ready;
  assign s1_load  = !s1_valid_q | s2_load;
  assign grant_en = s1_load & (|req_valid) & !rst;

  // Search from ptr upward; ptr < NREQ so one subtraction is enough to wrap.
  always_comb begin
    found   = 1'b0;
    win_id  = '0;
    cand    = '0;
    cand_id = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW + 1)'(k);
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      cand_id = cand[IDW-1:0];
      if (!found && req_valid[cand_id]) begin
        found  = 1'b1;
        win_id = cand_id;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id == IDW'(i)) begin
        sel_a = req_a[32*i +: 32];
        sel_b = req_b[32*i +: 32];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_en) begin
      req_ready = NREQ'(1) << win_id;
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_id_d     = s1_id_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    op_count_d  = op_count_q;

    // Operands hold on an idle cycle so the multiplier input does not toggle.
    if (s1_load) begin
      s1_valid_d = grant_en;
      if (grant_en) begin
        s1_id_d = win_id;
        mul_a_d = sel_a;
        mul_b_d = sel_b;
        ptr_d   = (win_id == LAST_ID) ? '0 : win_id + 1'b1;
      end
    end

    if (s2_load) begin
      rsp_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        rsp_data_d = mul_p;
        rsp_id_d   = s1_id_q;
      end
    end

    if (rsp_valid_q && rsp_ready) begin
      op_count_d = op_count_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      op_count_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_id_q     <= s1_id_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      op_count_q  <= op_count_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = s1_valid_q | rsp_valid_q;
  assign op_count  = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mul_rr_sched
// Purpose  : Self-checking bench for fp_mul_rr_sched with a behavioural
//            multiplier and an in-order response scoreboard.
// Revision : 1.0
// ============================================================================
module tb_fp_mul_rr_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [32*NREQ-1:0]  req_a;
  logic [32*NREQ-1:0]  req_b;
  logic [31:0]         mul_a;
  logic [31:0]         mul_b;
  logic [31:0]         mul_p;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [31:0]         rsp_data;
  logic                busy;
  logic [CNTW-1:0]     op_count;

  int checks = 0;
  int errors = 0;
  logic [IDW+31:0] sb_q[$];
  logic [IDW+31:0] sb_exp;

  fp_mul_rr_sched #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  // Truncating multiply for normal operands; enough for the values used here.
  function automatic logic [31:0] fpmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [9:0]  e;
    logic [47:0] m;
    s = a[31] ^ b[31];
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
    m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
    if (m[47]) begin
      e = e + 10'd1;
      return {s, e[7:0], m[46:24]};
    end
    return {s, e[7:0], m[45:23]};
  endfunction

  function automatic logic [31:0] opa(input int i);
    return 32'h3F80_0000 | (32'(i) << 20);
  endfunction

  function automatic logic [31:0] opb(input int i);
    return 32'h4000_0000 | (32'(i) << 19);
  endfunction

  assign mul_p = fpmul(mul_a, mul_b);

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb_q.push_back({IDW'(i), fpmul(req_a[32*i +: 32], req_b[32*i +: 32])});
        end
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got id=%0d data=%h, scoreboard empty", rsp_id, rsp_data);
        end else begin
          sb_exp = sb_q.pop_front();
          if ({rsp_id, rsp_data} !== sb_exp) begin
            errors++;
            $display("FAIL sb_rsp: got id=%0d data=%h expected id=%0d data=%h",
                     rsp_id, rsp_data, sb_exp[IDW+31:32], sb_exp[31:0]);
          end
        end
      end
    end
  end

  task automatic load_default_ops;
    for (int i = 0; i < NREQ; i++) begin
      req_a[32*i +: 32] = opa(i);
      req_b[32*i +: 32] = opb(i);
    end
  endtask

  task automatic do_reset;
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    load_default_ops();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    rsp_ready = 1'b1;
    load_default_ops();
    req_valid = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy);
    end
    checks++;
    if (mul_a !== 32'd0 || mul_b !== 32'd0 || rsp_data !== 32'd0 || rsp_id !== '0) begin
      errors++; $display("FAIL reset_data: got a=%h b=%h d=%h id=%0d expected zeros", mul_a, mul_b, rsp_data, rsp_id);
    end
    checks++;
    if (op_count !== '0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", op_count);
    end
    @(posedge clk);
    #1 rst = 1'b0; req_valid = '0;
  endtask

  task automatic test_single;
    bit ok;
    do_reset();
    req_a[31:0] = 32'h3FC0_0000;
    req_b[31:0] = 32'h4000_0000;
    req_valid   = 4'b0001;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL single_grant: got %b expected 0001", req_ready);
    end
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1 || mul_a !== 32'h3FC0_0000 || mul_b !== 32'h4000_0000) begin
      errors++; $display("FAIL single_s1: got v=%b busy=%b a=%h b=%h expected 0 1 3fc00000 40000000",
                         rsp_valid, busy, mul_a, mul_b);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'h4040_0000) begin
      errors++; $display("FAIL single_rsp: got v=%b id=%0d d=%h expected 1 0 40400000", rsp_valid, rsp_id, rsp_data);
    end
    drain(ok);
    checks++;
    if (!ok || op_count !== 4'd1) begin
      errors++; $display("FAIL single_count: got drained=%0d count=%0d expected 1 1", ok, op_count);
    end
  endtask

  task automatic test_fairness;
    bit ok;
    logic [NREQ-1:0] exp_g;
    do_reset();
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      exp_g = NREQ'(1) << (k % NREQ);
      @(negedge clk);
      checks++;
      if (req_ready !== exp_g) begin
        errors++; $display("FAIL fair_grant[%0d]: got %b expected %b", k, req_ready, exp_g);
      end
      @(posedge clk);
    end
    #1 req_valid = '0;
    drain(ok);
    checks++;
    if (!ok || op_count !== 4'd8) begin
      errors++; $display("FAIL fair_count: got drained=%0d count=%0d expected 1 8", ok, op_count);
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0110;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL bp_grant1: got %b expected 0010", req_ready);
    end
    @(posedge clk);
    #1 req_valid = 4'b0100;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL bp_grant2: got %b expected 0100", req_ready);
    end
    @(posedge clk);
    #1;
    req_a[32*1 +: 32] = opa(5); req_b[32*1 +: 32] = opb(5);
    req_a[32*2 +: 32] = opa(6); req_b[32*2 +: 32] = opb(6);
    req_valid = 4'b0110;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000 || mul_a !== opa(2) || rsp_valid !== 1'b1 || rsp_id !== 2'd1 ||
          rsp_data !== fpmul(opa(1), opb(1))) begin
        errors++; $display("FAIL bp_stall[%0d]: got rdy=%b a=%h v=%b id=%0d d=%h expected 0000 %h 1 1 %h",
                           k, req_ready, mul_a, rsp_valid, rsp_id, rsp_data, opa(2), fpmul(opa(1), opb(1)));
      end
      @(posedge clk);
    end
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || req_ready !== 4'b0010) begin
      errors++; $display("FAIL bp_rel1: got v=%b id=%0d rdy=%b expected 1 1 0010", rsp_valid, rsp_id, req_ready);
    end
    @(posedge clk);
    #1 req_valid = 4'b0100;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || req_ready !== 4'b0100) begin
      errors++; $display("FAIL bp_rel2: got v=%b id=%0d rdy=%b expected 1 2 0100", rsp_valid, rsp_id, req_ready);
    end
    @(posedge clk);
    #1 req_valid = '0;
    drain(ok);
    checks++;
    if (!ok || op_count !== 4'd4) begin
      errors++; $display("FAIL bp_count: got drained=%0d count=%0d expected 1 4", ok, op_count);
    end
  endtask

  task automatic test_ptr_skip;
    bit ok;
    do_reset();
    req_valid = 4'b1000;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++; $display("FAIL skip_g3: got %b expected 1000", req_ready);
    end
    @(posedge clk);
    #1 req_valid = 4'b0010;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL skip_g1: got %b expected 0010", req_ready);
    end
    @(posedge clk);
    #1 req_valid = 4'b1011;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000 || rsp_valid !== 1'b1 || rsp_id !== 2'd3) begin
      errors++; $display("FAIL skip_ptr2: got rdy=%b v=%b id=%0d expected 1000 1 3", req_ready, rsp_valid, rsp_id);
    end
    @(posedge clk);
    #1 req_valid = 4'b0011;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001 || rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin
      errors++; $display("FAIL skip_wrap: got rdy=%b v=%b id=%0d expected 0001 1 1", req_ready, rsp_valid, rsp_id);
    end
    @(posedge clk);
    #1 req_valid = '0;
    drain(ok);
    checks++;
    if (!ok || op_count !== 4'd4) begin
      errors++; $display("FAIL skip_count: got drained=%0d count=%0d expected 1 4", ok, op_count);
    end
  endtask

  task automatic test_reset_midflight;
    bit ok;
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0011;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL mid_grant: got %b expected 0001", req_ready);
    end
    @(posedge clk);
    #1 req_valid = 4'b0010;
    @(posedge clk);
    #1 rst = 1'b1; req_valid = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL mid_full: got busy=%b v=%b rdy=%b expected 1 1 0000", busy, rsp_valid, req_ready);
    end
    @(posedge clk);
    #1;
    rst         = 1'b0;
    rsp_ready   = 1'b1;
    req_a[31:0] = 32'h4040_0000;
    req_b[31:0] = 32'h4040_0000;
    req_valid   = 4'b0001;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== 4'd0 || req_ready !== 4'b0001) begin
      errors++; $display("FAIL mid_cleared: got v=%b busy=%b count=%0d rdy=%b expected 0 0 0 0001",
                         rsp_valid, busy, op_count, req_ready);
    end
    @(posedge clk);
    #1 req_valid = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'h4110_0000) begin
      errors++; $display("FAIL mid_nine: got v=%b id=%0d d=%h expected 1 0 41100000", rsp_valid, rsp_id, rsp_data);
    end
    drain(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL mid_drain: got timeout expected idle");
    end
  endtask

  task automatic test_counter_wrap;
    bit ok;
    do_reset();
    req_valid = 4'b0001;
    repeat (17) @(posedge clk);
    #1 req_valid = '0;
    drain(ok);
    checks++;
    if (!ok || op_count !== 4'd1) begin
      errors++; $display("FAIL wrap_count: got drained=%0d count=%0d expected 1 1", ok, op_count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_ptr_skip();
    test_reset_midflight();
    test_counter_wrap();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d pending expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
